// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encodings and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_WAIT = 4;
  // Wide enough for any MAX_WAIT in 1..15.
  localparam int WAIT_WIDTH = 4;

endpackage

// File: rtl/dmem_starve_counter.sv
// rtl/dmem_starve_counter.sv - saturating count of consecutive cycles the loader was denied
module dmem_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam logic [WAIT_WIDTH-1:0] MAX_CNT = WAIT_WIDTH'(MAX_WAIT);

  logic [WAIT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + WAIT_WIDTH'(1);
    end
  end

  assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data memory between the MEM stage and a burst loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ld_valid,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic [LEN_WIDTH-1:0]  ld_len,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ready,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic                  burst_we;
  logic                  in_burst;
  logic                  at_max;
  logic                  loader_gnt;

  assign in_burst = (state == BURST);
  // A beat coinciding with rst is dropped so an abandoned burst writes nothing further.
  assign loader_gnt = in_burst && !rst && (!cpu_req || at_max);

  dmem_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clear (loader_gnt || !in_burst),
    .inc   (in_burst && cpu_req && !loader_gnt),
    .at_max(at_max)
  );

  always_comb begin
    if (loader_gnt) begin
      mem_addr = ld_addr;
      mem_we   = burst_we;
      mem_data = ld_wdata;
    end else begin
      mem_addr = cpu_addr;
      mem_we   = cpu_req & cpu_we;
      mem_data = cpu_wdata;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = loader_gnt && cpu_req;
  assign ld_ready  = loader_gnt && burst_we;
  assign ld_rvalid = loader_gnt && !burst_we;
  assign ld_rdata  = mem_rdata;
  assign ld_busy   = (state != IDLE);
  assign ld_done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_addr    <= '0;
      beats_left <= '0;
      burst_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            ld_addr    <= ld_base;
            beats_left <= ld_len;
            burst_we   <= ld_we;
            state      <= (ld_len == '0) ? DONE : BURST;
          end
        end
        BURST: begin
          if (loader_gnt) begin
            ld_addr    <= (ld_addr == LAST_ADDR) ? '0 : ld_addr + ADDR_WIDTH'(1);
            beats_left <= beats_left - LEN_WIDTH'(1);
            if (beats_left == LEN_WIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with directed and random traffic
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 32;
  localparam int LW    = 8;
  localparam int MAXW  = 4;

  localparam int E_CPU   = 0;
  localparam int E_STALL = 1;
  localparam int E_LDW   = 2;
  localparam int E_LDR   = 3;
  localparam int E_DONE  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cpu_req, cpu_we, ld_valid, ld_we, mem_init;
  logic [AW-1:0] cpu_addr, ld_base;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic [LW-1:0] ld_len;
  logic [DW-1:0] cpu_rdata, ld_rdata, mem_data, mem_rdata;
  logic          cpu_stall, ld_ready, ld_rvalid, ld_busy, ld_done, mem_we;
  logic [AW-1:0] mem_addr;

  dmem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LEN_WIDTH(LW), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_valid(ld_valid), .ld_we(ld_we), .ld_base(ld_base), .ld_len(ld_len), .ld_wdata(ld_wdata),
    .ld_ready(ld_ready), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_busy(ld_busy), .ld_done(ld_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + DW'(i);
  endfunction

  // Memory behind the arbiter: combinational read, write on the clock edge.
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
    end else if (mem_we && (mem_addr < DEPTH)) begin
      tb_mem[mem_addr[4:0]] <= mem_data;
    end
  end
  assign mem_rdata = (mem_addr < DEPTH) ? tb_mem[mem_addr[4:0]] : '0;

  typedef struct {
    int            kind;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;
  ev_t exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic mon_pop(input int kind);
    ev_t  e;
    logic ok;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_output: kind %0d at cycle %0d, nothing expected", kind, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc);
    case (kind)
      E_CPU:   ok &= e.we ? (mem_we && mem_addr == e.addr && mem_data == e.data)
                          : (!mem_we && mem_addr == e.addr && cpu_rdata == e.data);
      E_LDW:   ok &= mem_we && (mem_addr == e.addr) && (mem_data == e.data);
      E_LDR:   ok &= !mem_we && (mem_addr == e.addr) && (ld_rdata == e.data);
      default: ;
    endcase
    if (ok) passed++;
    else $display("FAIL scoreboard: got kind %0d cyc %0d addr %h wdata %h cpu_rdata %h ld_rdata %h, expected kind %0d cyc %0d addr %h data %h",
                  kind, cyc, mem_addr, mem_data, cpu_rdata, ld_rdata, e.kind, e.cyc, e.addr, e.data);
  endtask

  // Monitor: every output the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_req && !cpu_stall) mon_pop(E_CPU);
      if (cpu_stall)             mon_pop(E_STALL);
      if (ld_ready)              mon_pop(E_LDW);
      if (ld_rvalid)             mon_pop(E_LDR);
      if (ld_done)               mon_pop(E_DONE);
    end
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      $display("FAIL missing_output: expected kind %0d at cycle %0d, not presented", exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  // Reference model: pending beat addresses in a queue, a denied-cycle count, a word array.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] pend_q[$];
  logic          m_we = 1'b0;
  logic          m_stalled = 1'b0;
  logic          m_done_next = 1'b0;
  int            m_denied = 0;

  function automatic void push(input int kind, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.we = we; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_cycle();
    logic          active, gnt, done_now;
    logic [AW-1:0] b;
    if (rst) begin
      pend_q.delete();
      m_done_next = 1'b0;
      m_denied    = 0;
      m_stalled   = 1'b0;
      return;
    end
    b         = '0;
    active    = (pend_q.size() != 0);
    gnt       = active && (!cpu_req || m_denied == MAXW);
    m_stalled = gnt && cpu_req;
    if (cpu_req && !m_stalled)
      push(E_CPU, cpu_we, cpu_addr, cpu_we ? cpu_wdata : ref_mem[cpu_addr[4:0]]);
    if (m_stalled) push(E_STALL, 1'b0, '0, '0);
    if (gnt) begin
      b = pend_q.pop_front();
      push(m_we ? E_LDW : E_LDR, m_we, b, m_we ? ld_wdata : ref_mem[b[4:0]]);
      m_denied = 0;
    end else if (active && cpu_req) begin
      m_denied = (m_denied < MAXW) ? m_denied + 1 : MAXW;
    end
    if (gnt && m_we) ref_mem[b[4:0]] = ld_wdata;
    if (cpu_req && !m_stalled && cpu_we) ref_mem[cpu_addr[4:0]] = cpu_wdata;
    done_now = m_done_next;
    if (done_now) push(E_DONE, 1'b0, '0, '0);
    m_done_next = gnt && (pend_q.size() == 0);
    if (!active && !done_now && ld_valid) begin
      m_we     = ld_we;
      m_denied = 0;
      if (ld_len == '0) m_done_next = 1'b1;
      else for (int i = 0; i < int'(ld_len); i++) pend_q.push_back(AW'((int'(ld_base) + i) % DEPTH));
    end
  endfunction

  task automatic step(input logic r, input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input logic lv, input logic lwe, input logic [AW-1:0] lbase,
                      input logic [LW-1:0] llen, input logic [DW-1:0] lwd);
    @(posedge clk);
    #1;
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ld_valid = lv; ld_we = lwe; ld_base = lbase; ld_len = llen; ld_wdata = lwd;
    model_cycle();
    #1;
  endtask

  task automatic cpu_step(input logic creq, input logic cwe, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, creq, cwe, a, d, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic ld_beat(input logic [DW-1:0] d);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2:0]    exp3;
  logic          h_req, h_we, r;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wd;
  int            busy_pct;

  initial begin
    rst = 1'b1; mem_init = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_valid = 1'b0; ld_we = 1'b0; ld_base = '0; ld_len = '0; ld_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    mem_init = 1'b0;

    // Idle CPU read straight after reset.
    cpu_step(1'b1, 1'b0, 32'd5, '0);
    chk("reset_loader_flags", {60'd0, ld_ready, ld_rvalid, ld_busy, ld_done}, 64'd0);
    chk("idle_cpu_rdata", cpu_rdata, 64'hDEADBEEF);
    chk("idle_cpu_stall", cpu_stall, 0);

    // Write burst wrapping past the last word.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd30, 8'd4, '0);
    for (int k = 1; k <= 4; k++) begin
      ld_beat(DW'(32'h11 * k));
      chk("wr_burst_ld_ready", ld_ready, 1);
    end
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("wr_burst_done_pulse", ld_done, 1);
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("wr_burst_done_clear", {ld_done, ld_busy}, 0);
    chk("wrap_word30", tb_mem[30], 64'h11);
    chk("wrap_word31", tb_mem[31], 64'h22);
    chk("wrap_word0", tb_mem[0], 64'h33);
    chk("wrap_word1", tb_mem[1], 64'h44);

    // Read burst against a continuously requesting CPU: beats forced at cycles 5 and 10.
    step(1'b0, 1'b1, 1'b0, 32'd3, '0, 1'b1, 1'b0, 32'd5, 8'd2, '0);
    for (int k = 1; k <= 11; k++) begin
      cpu_step(1'b1, 1'b0, 32'd3, '0);
      exp3 = {(k == 5 || k == 10), (k == 5 || k == 10), (k == 11)};
      chk("starve_rvalid_stall_done", {ld_rvalid, cpu_stall, ld_done}, exp3);
    end

    // CPU write caught by a forced beat is held and lands one cycle later.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd9, 8'd1, '0);
    for (int k = 1; k <= 4; k++) cpu_step(1'b1, 1'b0, 32'd3, '0);
    cpu_step(1'b1, 1'b1, 32'd7, 32'hCAFE0007);
    chk("stalled_write_stall", cpu_stall, 1);
    cpu_step(1'b1, 1'b1, 32'd7, 32'hCAFE0007);
    chk("stalled_write_not_done", tb_mem[7], init_word(7));
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("held_write_done", tb_mem[7], 64'hCAFE0007);

    // Zero-length burst.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd3, 8'd0, 32'h5555_5555);
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("len0_done", ld_done, 1);
    chk("len0_no_access", {ld_ready, mem_we}, 0);
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("len0_back_idle", {ld_done, ld_busy}, 0);

    // Reset on the second beat of a write burst.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd12, 8'd4, '0);
    ld_beat(32'hAAAA0001);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 32'hAAAA0002);
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("rst_burst_idle", {ld_busy, ld_done, ld_ready}, 0);
    cpu_step(1'b0, 1'b0, '0, '0);
    chk("rst_burst_no_done", ld_done, 0);
    chk("rst_burst_beat1", tb_mem[12], 64'hAAAA0001);
    chk("rst_burst_beat2", tb_mem[13], init_word(13));

    // Random traffic; a stalled CPU keeps its request unchanged.
    busy_pct = 50;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 300 == 0) busy_pct = (busy_pct == 95) ? 40 : 95;
      if (!m_stalled) begin
        h_req  = ($urandom_range(99) < busy_pct);
        h_we   = 1'($urandom_range(1));
        h_addr = AW'($urandom_range(DEPTH - 1));
        h_wd   = $urandom;
      end
      r = ($urandom_range(499) == 0);
      step(r, h_req && !r, h_we, h_addr, h_wd,
           ($urandom_range(99) < 15), 1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)),
           LW'($urandom_range(6)), $urandom);
    end
    for (int n = 0; n < 40; n++) cpu_step(1'b0, 1'b0, '0, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
